// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving an external comparator.
// Resolves the target MSB first with early exit on equality.
module sar_search_ctrl #(
    parameter  int WIDTH = 4,
    localparam int SW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [SW-1:0]    steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_guess;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [SW-1:0]    r_steps;
    logic [SW-1:0]    r_ptr;
    logic [SW-1:0]    r_cnt;

    logic             w_valid;
    logic             w_last;
    logic             w_exit;
    logic             w_err;
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_guess_nxt;

    // Flags are trusted only when exactly one of them is asserted.
    assign w_valid = (cmp_gt & ~cmp_lt & ~cmp_eq)
                   | (~cmp_gt & cmp_lt & ~cmp_eq)
                   | (~cmp_gt & ~cmp_lt & cmp_eq);
    assign w_last  = (r_ptr == '0);
    assign w_exit  = ~w_valid | cmp_eq | w_last;
    assign w_err   = ~w_valid | (cmp_gt & w_last);
    assign w_bit   = WIDTH'(1) << r_ptr;
    assign w_res   = (w_valid & cmp_lt & w_last) ? (r_guess & ~w_bit) : r_guess;

    assign w_guess_nxt = (cmp_gt ? r_guess : (r_guess & ~w_bit)) | (w_bit >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_SEARCH;
            S_SEARCH: if (w_exit) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SEARCH);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guess  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_steps  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_guess <= WIDTH'(1) << (WIDTH - 1);
                        r_ptr   <= SW'(WIDTH - 1);
                        r_cnt   <= SW'(1);
                    end
                end
                S_SEARCH: begin
                    if (w_exit) begin
                        r_result <= w_res;
                        r_err    <= w_err;
                        r_steps  <= r_cnt;
                        r_guess  <= '0;
                    end else begin
                        r_guess <= w_guess_nxt;
                        r_ptr   <= r_ptr - SW'(1);
                        r_cnt   <= r_cnt + SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign guess  = r_guess;
    assign result = r_result;
    assign err    = r_err;
    assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: vector table, random targets
// against an arithmetic reference, and hand-written multi-cycle sequences.
module tb_sar_search_ctrl;

    localparam int WIDTH = 4;
    localparam int SW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;
    logic [SW-1:0]    steps;

    int n_checks;
    int n_errors;
    int target;
    int fault;
    int cur_cyc;

    sar_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .steps  (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model with fault injection:
    // fault 1 = gt and lt both high on step 2, fault 2 = all flags low on step 1.
    always_comb begin
        cmp_gt = 1'b0;
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        if (fault == 1 && cur_cyc == 2) begin
            cmp_gt = 1'b1;
            cmp_lt = 1'b1;
        end else if (fault == 2 && cur_cyc == 1) begin
            cmp_gt = 1'b0;
        end else begin
            cmp_gt = (target > int'(guess));
            cmp_lt = (target < int'(guess));
            cmp_eq = (target == int'(guess));
        end
    end

    typedef struct {
        int    t;
        int    f;
        int    res;
        int    e;
        int    st;
        string nm;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Binary search over [0, 2^W-1]: a consistent target is found exactly,
    // after one probe per bit down to its lowest set bit.
    function automatic void model(input int t, output int r, output int e,
                                  output int s);
        int tz;
        if (t > (1 << WIDTH) - 1) begin
            r = (1 << WIDTH) - 1;
            e = 1;
            s = WIDTH;
        end else begin
            r  = t;
            e  = 0;
            tz = 0;
            while (t != 0 && ((t >> tz) & 1) == 0) tz++;
            s = (t == 0) ? WIDTH : WIDTH - tz;
        end
    endfunction

    task automatic run_search(input int t, input int f, input int xs,
                              input int er, input int ee, input int es,
                              input string nm);
        int cyc;
        target = t;
        fault  = f;
        @(negedge clk);
        start   = 1'b1;
        cur_cyc = 0;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        cur_cyc = 1;
        check({nm, " busy"}, int'(busy), 1);
        check({nm, " guess0"}, int'(guess), 1 << (WIDTH - 1));
        while (!done && cyc < WIDTH + 4) begin
            @(negedge clk);
            cyc++;
            cur_cyc = cyc;
            start = (cyc == xs);
        end
        start = 1'b0;
        check({nm, " done"}, int'(done), 1);
        check({nm, " latency"}, cyc, es + 1);
        check({nm, " result"}, int'(result), er);
        check({nm, " err"}, int'(err), ee);
        check({nm, " steps"}, int'(steps), es);
        check({nm, " busy_off"}, int'(busy), 0);
        check({nm, " guess_off"}, int'(guess), 0);
        @(negedge clk);
        cur_cyc = 0;
        check({nm, " pulse"}, int'(done), 0);
        @(negedge clk);
        check({nm, " idle"}, int'(busy), 0);
    endtask

    vec_t vecs[$];

    initial begin
        int r;
        int e;
        int s;
        int dcyc[$];
        n_checks = 0;
        n_errors = 0;
        target   = 0;
        fault    = 0;
        cur_cyc  = 0;
        start    = 1'b0;
        rst_n    = 1'b0;

        vecs.push_back('{10, 0, 10, 0, 3, "t10"});
        vecs.push_back('{8,  0, 8,  0, 1, "t8"});
        vecs.push_back('{0,  0, 0,  0, 4, "t0"});
        vecs.push_back('{15, 0, 15, 0, 4, "t15"});
        vecs.push_back('{12, 0, 12, 0, 2, "t12"});
        vecs.push_back('{10, 1, 12, 1, 2, "fault_gtlt"});
        vecs.push_back('{10, 2, 8,  1, 1, "fault_none"});
        vecs.push_back('{16, 0, 15, 1, 4, "fault_gtlast"});

        #12;
        check("rst guess", int'(guess), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst result", int'(result), 0);
        check("rst err", int'(err), 0);
        check("rst steps", int'(steps), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_search(vecs[i].t, vecs[i].f, 0, vecs[i].res, vecs[i].e,
                       vecs[i].st, vecs[i].nm);

        for (int t = 0; t < (1 << WIDTH); t++) begin
            model(t, r, e, s);
            run_search(t, 0, 0, r, e, s, $sformatf("sweep%0d", t));
        end

        for (int k = 0; k < 12; k++) begin
            int t;
            t = int'($urandom_range(0, (1 << WIDTH)));
            model(t, r, e, s);
            run_search(t, 0, 0, r, e, s, $sformatf("rand%0d_t%0d", k, t));
        end

        run_search(15, 0, 2, 15, 0, 4, "start_in_search");
        @(negedge clk);
        check("no_restart busy", int'(busy), 0);

        // Reset mid-search: outputs clear at once and no done follows.
        target = 15;
        fault  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst guess", int'(guess), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst result", int'(result), 0);
        check("midrst err", int'(err), 0);
        check("midrst steps", int'(steps), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            check("midrst nodone", int'(done), 0);
        end

        // Start held high with the slowest target: done every WIDTH+2 cycles.
        target = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 40 && dcyc.size() < 3; c++) begin
            @(negedge clk);
            if (done) dcyc.push_back(c);
        end
        start = 1'b0;
        check("held count", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            check("held first", dcyc[0], WIDTH + 1);
            check("held gap1", dcyc[1] - dcyc[0], WIDTH + 2);
            check("held gap2", dcyc[2] - dcyc[1], WIDTH + 2);
        end
        repeat (WIDTH + 3) @(negedge clk);
        check("held result", int'(result), 0);
        check("held steps", int'(steps), WIDTH);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
